// File: rtl/dispatch_pkg.sv
// Shared types and constants for the reservation-station dispatch slice.
package dispatch_pkg;

  localparam int unsigned INT_WIDTH = 73;
  localparam int unsigned LS_WIDTH  = 105;
  localparam int unsigned BR_WIDTH  = 106;

  localparam logic [2:0] RS_NONE       = 3'b000;
  localparam logic [2:0] RS_INTEGER    = 3'b001;
  localparam logic [2:0] RS_BRANCH     = 3'b010;
  localparam logic [2:0] RS_LOAD_STORE = 3'b100;

  typedef struct packed {
    logic [31:0]         pc;
    logic [2:0]          dest;
    logic [BR_WIDTH-1:0] payload;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                wr;
    logic                use1;
    logic                use2;
  } dispatch_entry_t;

  // RAW on either source or WAW on the destination; x0 never blocks.
  function automatic logic has_hazard(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic wr,
                                      input logic use1, input logic use2,
                                      input logic [31:0] busy);
    return (use1 && rs1 != '0 && busy[rs1]) ||
           (use2 && rs2 != '0 && busy[rs2]) ||
           (wr   && rd  != '0 && busy[rd]);
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Circular buffer of decoded entries; count-based full/empty, synchronous flush.
module dispatch_fifo
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  dispatch_entry_t din,
  output logic            full,
  output logic            empty,
  output dispatch_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  dispatch_entry_t mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dispatch_unit.sv
// Issues buffered decode entries to the reservation stations, one per cycle,
// gated by Execute stall, kill flush and a per-register busy scoreboard.
module dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned INT_W = INT_WIDTH,
  parameter int unsigned LS_W  = LS_WIDTH,
  parameter int unsigned BR_W  = BR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic             stall,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [31:0]      dec_pc,
  input  logic [2:0]       dec_dest,
  input  logic [BR_W-1:0]  dec_payload,
  input  logic [4:0]       dec_rd,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_wr,
  input  logic             dec_use1,
  input  logic             dec_use2,
  input  logic             complete_valid,
  input  logic [4:0]       complete_rd,
  output logic [31:0]      dispatched_pc,
  output logic [2:0]       rs_destination,
  output logic [INT_W-1:0] rs_integer,
  output logic [LS_W-1:0]  rs_loadstore,
  output logic [BR_W-1:0]  rs_branch
);

  dispatch_entry_t din;
  dispatch_entry_t head;
  logic            full;
  logic            empty;
  logic            push;
  logic            issue;
  logic [31:1]     busy;

  assign din = '{pc: dec_pc, dest: dec_dest, payload: dec_payload, rd: dec_rd,
                 rs1: dec_rs1, rs2: dec_rs2, wr: dec_wr, use1: dec_use1, use2: dec_use2};

  assign dec_ready = !full && !reset;
  assign push      = dec_valid && dec_ready && !kill;
  assign issue     = !empty && !stall && !kill &&
                     !has_hazard(head.rd, head.rs1, head.rs2, head.wr, head.use1,
                                 head.use2, {busy, 1'b0});

  dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (kill),
    .push  (push),
    .pop   (issue),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // A register issued and retired in the same cycle stays busy: the new writer wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (kill) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        if (issue && head.wr && head.rd == 5'(i))
          busy[i] <= 1'b1;
        else if (complete_valid && complete_rd == 5'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_destination <= RS_NONE;
      dispatched_pc  <= '0;
      rs_integer     <= '0;
      rs_loadstore   <= '0;
      rs_branch      <= '0;
    end else if (kill || (!stall && !issue)) begin
      rs_destination <= RS_NONE;
      rs_integer     <= '0;
      rs_loadstore   <= '0;
      rs_branch      <= '0;
    end else if (issue) begin
      rs_destination <= head.dest;
      dispatched_pc  <= head.pc;
      rs_integer     <= (head.dest == RS_INTEGER)    ? head.payload[INT_W-1:0] : '0;
      rs_loadstore   <= (head.dest == RS_LOAD_STORE) ? head.payload[LS_W-1:0]  : '0;
      rs_branch      <= (head.dest == RS_BRANCH)     ? head.payload[BR_W-1:0]  : '0;
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Randomized scoreboard bench for dispatch_unit against a queue-level reference model.
module tb_dispatch_unit;
  import dispatch_pkg::*;

  localparam int DEPTH = 4;

  logic         clk, reset, kill, stall, dec_valid, dec_ready;
  logic [31:0]  dec_pc, dispatched_pc;
  logic [2:0]   dec_dest, rs_destination;
  logic [105:0] dec_payload, rs_branch;
  logic [4:0]   dec_rd, dec_rs1, dec_rs2, complete_rd;
  logic         dec_wr, dec_use1, dec_use2, complete_valid;
  logic [72:0]  rs_integer;
  logic [104:0] rs_loadstore;

  dispatch_unit #(.DEPTH(DEPTH), .INT_W(73), .LS_W(105), .BR_W(106)) dut (
    .clk(clk), .reset(reset), .kill(kill), .stall(stall),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_dest(dec_dest),
    .dec_payload(dec_payload), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_wr(dec_wr), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .complete_valid(complete_valid), .complete_rd(complete_rd),
    .dispatched_pc(dispatched_pc), .rs_destination(rs_destination),
    .rs_integer(rs_integer), .rs_loadstore(rs_loadstore), .rs_branch(rs_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  pc;
    logic [2:0]   dest;
    logic [105:0] pl;
    int           rd, rs1, rs2;
    bit           wr, use1, use2;
  } ment_t;

  typedef struct {
    int unsigned  cyc;
    logic [2:0]   dest;
    logic [31:0]  pc;
    logic [105:0] pl;
  } exp_t;

  ment_t       mq[$];
  exp_t        expq[$];
  bit [31:0]   mbusy;
  int unsigned cyc;
  bit          st_e, kl_e;
  int          passed, total;

  task automatic chk(input bit ok, input string nm, input string act, input string req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %s, expected %s", nm, act, req);
  endtask

  function automatic bit hz(input ment_t e);
    return (e.use1 && e.rs1 != 0 && mbusy[e.rs1]) ||
           (e.use2 && e.rs2 != 0 && mbusy[e.rs2]) ||
           (e.wr   && e.rd  != 0 && mbusy[e.rd]);
  endfunction

  // Reference model: in-order queue, busy-register set, one issue per unstalled cycle.
  ment_t h;
  bit    issued, can_push;
  always @(posedge clk) begin
    cyc++;
    st_e = stall;
    kl_e = kill;
    if (reset) begin
      mq.delete(); expq.delete(); mbusy = '0;
    end else if (kill) begin
      mq.delete(); mbusy = '0;
    end else begin
      can_push = mq.size() < DEPTH;
      issued   = 1'b0;
      if (!stall && mq.size() > 0 && !hz(mq[0])) begin
        h = mq.pop_front();
        issued = 1'b1;
        expq.push_back('{cyc, h.dest, h.pc, h.pl});
      end
      if (complete_valid && complete_rd != 0) mbusy[complete_rd] = 1'b0;
      if (issued && h.wr && h.rd != 0) mbusy[h.rd] = 1'b1;
      if (dec_valid && can_push)
        mq.push_back('{dec_pc, dec_dest, dec_payload, int'(dec_rd), int'(dec_rs1),
                       int'(dec_rs2), dec_wr, dec_use1, dec_use2});
    end
  end

  // Monitor: expected output state advances only on unstalled or killed edges.
  logic [2:0]   ed;
  logic [31:0]  epc;
  logic [105:0] epl;
  logic [72:0]  ei;
  logic [104:0] el;
  logic [105:0] eb;
  exp_t         r;
  always @(negedge clk) begin
    if (reset) begin
      ed = RS_NONE; epc = '0; epl = '0;
      chk(rs_destination == RS_NONE && dispatched_pc == 0 && rs_integer == 0 &&
          rs_loadstore == 0 && rs_branch == 0 && !dec_ready, "reset_state",
          $sformatf("dest=%0d pc=%h rdy=%b", rs_destination, dispatched_pc, dec_ready),
          "dest=0 pc=0 payloads=0 rdy=0");
    end else begin
      if (kl_e || !st_e) begin
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
          r = expq.pop_front();
          ed = r.dest; epc = r.pc; epl = r.pl;
        end else begin
          ed = RS_NONE; epl = '0;
        end
      end
      ei = (ed == RS_INTEGER)    ? epl[72:0]  : '0;
      el = (ed == RS_LOAD_STORE) ? epl[104:0] : '0;
      eb = (ed == RS_BRANCH)     ? epl        : '0;
      chk(rs_destination == ed && dispatched_pc == epc && rs_integer == ei &&
          rs_loadstore == el && rs_branch == eb, $sformatf("issue_c%0d", cyc),
          $sformatf("dest=%0d pc=%h int=%h ls=%h br=%h", rs_destination, dispatched_pc,
                    rs_integer, rs_loadstore, rs_branch),
          $sformatf("dest=%0d pc=%h int=%h ls=%h br=%h", ed, epc, ei, el, eb));
      chk(dec_ready == (mq.size() < DEPTH), "dec_ready",
          $sformatf("%b", dec_ready), $sformatf("%b", mq.size() < DEPTH));
      chk(dut.busy == mbusy[31:1], "scoreboard",
          $sformatf("%h", dut.busy), $sformatf("%h", mbusy[31:1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [105:0] rand_pl();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[105:0];
  endfunction

  task automatic set_entry(input logic [31:0] pc, input logic [2:0] dest, input int rd,
                           input int rs1, input int rs2, input bit wr, input bit u1,
                           input bit u2);
    dec_valid = 1'b1; dec_pc = pc; dec_dest = dest; dec_payload = rand_pl();
    dec_rd = 5'(rd); dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
    dec_wr = wr; dec_use1 = u1; dec_use2 = u2;
  endtask

  task automatic complete(input int rd);
    complete_valid = 1'b1;
    complete_rd = 5'(rd);
  endtask

  task automatic idle(input int n);
    dec_valid = 1'b0; complete_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic logic [2:0] rand_dest();
    case ($urandom_range(0, 4))
      0: return RS_INTEGER;
      1: return RS_BRANCH;
      2: return RS_LOAD_STORE;
      3: return 3'b111;
      default: return RS_INTEGER;
    endcase
  endfunction

  function automatic int pick_busy();
    int cand[$];
    for (int i = 1; i < 32; i++) if (mbusy[i]) cand.push_back(i);
    if (cand.size() == 0) return $urandom_range(0, 7);
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  logic [31:0] rpc;
  initial begin
    passed = 0; total = 0; cyc = 0; mbusy = '0;
    reset = 1'b1; kill = 1'b0; stall = 1'b0; dec_valid = 1'b0; complete_valid = 1'b0;
    dec_pc = '0; dec_dest = '0; dec_payload = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
    dec_wr = 1'b0; dec_use1 = 1'b0; dec_use2 = 1'b0; complete_rd = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Single integer issue, sets busy[5]
    set_entry(32'h100, RS_INTEGER, 5, 0, 0, 1, 0, 0); step();
    idle(3);
    // RAW: consumer of r6 waits for its completion
    complete(5); dec_valid = 1'b0; step();
    set_entry(32'h200, RS_INTEGER, 6, 1, 2, 1, 1, 1); complete_valid = 1'b0; step();
    set_entry(32'h204, RS_BRANCH, 0, 6, 0, 0, 1, 0); step();
    idle(4);
    complete(6); step();
    idle(3);
    // Fill while stalled, one extra push refused, then drain in order with wrap
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_entry(32'(4 * i), rand_dest(), 0, 0, 0, 0, 0, 0); step();
    end
    idle(2);
    stall = 1'b0;
    idle(6);
    // Kill with queued entries, busy[7] set and a concurrent push
    set_entry(32'h300, RS_LOAD_STORE, 7, 0, 0, 1, 0, 0); step();
    idle(2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_entry(32'h310 + 32'(4 * i), RS_INTEGER, 0, 0, 0, 0, 0, 0); step();
    end
    kill = 1'b1; set_entry(32'h999, RS_BRANCH, 3, 0, 0, 1, 0, 0); step();
    kill = 1'b0; stall = 1'b0;
    idle(3);
    // Issue and retire r9 on the same edge
    set_entry(32'h400, RS_BRANCH, 9, 0, 0, 1, 0, 0); step();
    dec_valid = 1'b0; complete(9); step();
    idle(2);
    complete(9); step();
    idle(1);

    // Random traffic with a mid-stream asynchronous reset
    rpc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        dec_valid = 1'b0; complete_valid = 1'b0; stall = 1'b0; kill = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk(rs_destination == RS_NONE && dispatched_pc == 0 && rs_integer == 0 &&
            rs_loadstore == 0 && rs_branch == 0 && !dec_ready, "async_reset",
            $sformatf("dest=%0d pc=%h rdy=%b", rs_destination, dispatched_pc, dec_ready),
            "dest=0 pc=0 payloads=0 rdy=0");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
      end
      stall = ($urandom_range(0, 99) < 20);
      kill  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 60) begin
        set_entry(rpc, rand_dest(), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        rpc += 4;
      end else begin
        dec_valid = 1'b0;
      end
      complete_valid = ($urandom_range(0, 99) < 40);
      complete_rd = 5'(pick_busy());
      step();
    end

    // Drain: retire outstanding registers until everything has issued
    stall = 1'b0; kill = 1'b0; dec_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mq.size() == 0 && expq.size() == 0) break;
      complete(pick_busy());
      step();
    end
    idle(2);
    chk(mq.size() == 0 && expq.size() == 0, "drain",
        $sformatf("queued=%0d pending=%0d", mq.size(), expq.size()), "queued=0 pending=0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
